// File: rtl/clk_en_pkg.sv
// ============================================================================
// clk_en_pkg : shared clock constants and divisor helpers for clk_en_gen
// Revision   : 1.0
// ============================================================================
`default_nettype none

package clk_en_pkg;

    localparam int unsigned CLK_FREQ_HZ = 100_000_000;

    function automatic int unsigned hz_to_div(input int unsigned freq);
        return CLK_FREQ_HZ / freq;
    endfunction

    localparam int unsigned DIV_1HZ   = hz_to_div(1);
    localparam int unsigned DIV_2HZ   = hz_to_div(2);
    localparam int unsigned DIV_400HZ = hz_to_div(400);
    localparam int unsigned DIV_4HZ   = hz_to_div(4);

endpackage

`default_nettype wire

// File: rtl/clk_en_chan.sv
// ============================================================================
// clk_en_chan : one divider channel producing a tick enable and a square level
// Revision    : 1.0
// ============================================================================
`default_nettype none

module clk_en_chan #(
    parameter int              CNT_W = 27,
    parameter longint unsigned DIV   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic adv,
    input  logic clr,
    output logic tick,
    output logic level
);

    if ((DIV == 0) || (DIV >= (64'd1 << CNT_W))) begin : g_bad_div
        $error("clk_en_chan: DIV must be in 1 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'((DIV + 1) / 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             level_q, level_d;

    always_comb begin
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        level_d = level_q;
        if (clr) begin
            // Clear wins over a coincident terminal count; that tick is dropped.
            cnt_d   = '0;
            level_d = 1'b1;
        end else if (adv) begin
            if (cnt_q == TERM) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            level_d = (cnt_d < HALF);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            level_q <= level_d;
        end
    end

    assign tick  = tick_q;
    assign level = level_q;

endmodule

`default_nettype wire

// File: rtl/clk_en_gen.sv
// ============================================================================
// clk_en_gen : multi-channel clock-enable generator with pause, clear and mask
// Revision   : 1.0
// ============================================================================
`default_nettype none

module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int                       N_CH     = 4,
    parameter int                       CNT_W    = 27,
    parameter logic [N_CH*CNT_W-1:0]    DIV_VALS = {27'(DIV_4HZ), 27'(DIV_400HZ),
                                                    27'(DIV_2HZ), 27'(DIV_1HZ)}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            clr,
    input  logic [N_CH-1:0] ch_en,
    output logic [N_CH-1:0] tick,
    output logic [N_CH-1:0] level,
    output logic [7:0]      wrap_cnt
);

    if ((N_CH < 1) || (N_CH > 8)) begin : g_bad_nch
        $error("clk_en_gen: N_CH must be in 1 .. 8");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        clk_en_chan #(
            .CNT_W (CNT_W),
            .DIV   ({{(64-CNT_W){1'b0}}, DIV_VALS[i*CNT_W +: CNT_W]})
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (en & ch_en[i]),
            .clr   (clr),
            .tick  (tick[i]),
            .level (level[i])
        );
    end

    logic [7:0] wrap_cnt_q, wrap_cnt_d;

    // Counts registered ch0 ticks as they are presented; wraps naturally at 8 bits.
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (clr) begin
            wrap_cnt_d = '0;
        end else if (tick[0]) begin
            wrap_cnt_d = wrap_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_cnt_q <= '0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign wrap_cnt = wrap_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_en_gen.sv
// ============================================================================
// tb_clk_en_gen : randomized scoreboard bench for clk_en_gen
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_clk_en_gen;

    localparam int N = 4;
    localparam int W = 4;
    // ch0=3, ch1=4, ch2=1, ch3=5
    localparam logic [N*W-1:0] DIVS_PACKED = {4'd5, 4'd1, 4'd4, 4'd3};
    localparam int DIVS [N] = '{3, 4, 1, 5};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         clr;
    logic [N-1:0] ch_en;
    logic [N-1:0] tick;
    logic [N-1:0] level;
    logic [7:0]   wrap_cnt;

    clk_en_gen #(
        .N_CH     (N),
        .CNT_W    (W),
        .DIV_VALS (DIVS_PACKED)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .ch_en    (ch_en),
        .tick     (tick),
        .level    (level),
        .wrap_cnt (wrap_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] tick;
        logic [N-1:0] level;
        logic [7:0]   wrap;
    } exp_t;

    exp_t q [$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: advances since the last reset/clear, per channel.
    int unsigned  n_adv [N];
    logic [N-1:0] tick_e;
    logic [N-1:0] lvl_e;
    logic [7:0]   wrap_e;

    task automatic model_reset();
        for (int i = 0; i < N; i++) n_adv[i] = 0;
        tick_e = '0;
        lvl_e  = '0;
        wrap_e = '0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic c, input logic [N-1:0] m);
        exp_t x;
        @(negedge clk);
        en    = e;
        clr   = c;
        ch_en = m;
        if (c) wrap_e = 8'd0;
        else   wrap_e = wrap_e + {7'd0, tick_e[0]};
        for (int i = 0; i < N; i++) begin
            if (c) begin
                n_adv[i] = 0;
                tick_e[i] = 1'b0;
                lvl_e[i]  = 1'b1;
            end else if (e && m[i]) begin
                n_adv[i]++;
                tick_e[i] = ((n_adv[i] % DIVS[i]) == 0);
                lvl_e[i]  = ((n_adv[i] % DIVS[i]) < ((DIVS[i] + 1) / 2));
            end else begin
                tick_e[i] = 1'b0;
            end
        end
        x.tick  = tick_e;
        x.level = lvl_e;
        x.wrap  = wrap_e;
        q.push_back(x);
    endtask

    task automatic drive_random();
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = ($urandom_range(0, 7) != 0);
        drive($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0, m);
    endtask

    task automatic drain();
        int budget = 10;
        while (q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(negedge clk);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expected entries never compared", q.size());
            q.delete();
        end
    endtask

    // Monitor: outputs are valid every cycle; compare one entry per clock.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() != 0) begin
                x = q.pop_front();
                chk("tick",     32'(tick),     32'(x.tick));
                chk("level",    32'(level),    32'(x.level));
                chk("wrap_cnt", 32'(wrap_cnt), 32'(x.wrap));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        ch_en = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tick",  32'(tick),     32'd0);
        chk("reset_level", 32'(level),    32'd0);
        chk("reset_wrap",  32'(wrap_cnt), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // Free run long enough for ch0 ticks to wrap wrap_cnt past 255.
        repeat (900) drive(1'b1, 1'b0, {N{1'b1}});
        repeat (2000) drive_random();
        drain();

        // Asynchronous reset, deliberately off the clock edges.
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tick",  32'(tick),     32'd0);
        chk("async_rst_level", 32'(level),    32'd0);
        chk("async_rst_wrap",  32'(wrap_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("held_rst_level", 32'(level), 32'd0);
        model_reset();
        @(negedge clk);
        en    = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b1;

        repeat (400) drive_random();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
